mem_port_scheduler: RTL

Clocked two-requester scheduler sharing one memory access port in the FPGA control path. Each requester raises a single-cycle `i_driveN` pulse with an address. The block queues one request per port, arbitrates round-robin and issues one `o_driveNext` pulse with the selected address. It then waits for the memory's `i_freeNext` completion pulse and returns `o_freeN` to the granted requester. It serialises the drive/free handshake that the two-way merge stage joins, so the memory never sees two overlapping accesses.

---
 rtl/mem_port_scheduler.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_scheduler.sv
// mem_port_scheduler
// Shares one memory access port between two requesters. Each requester posts a
// single-cycle drive pulse with an address; the block holds one request per
// port, grants round-robin, issues one o_driveNext pulse for the winner, waits
// for the memory completion pulse and returns o_freeN to the granted requester.
//
// Handshake: every request, issue and completion signal is a 1-cycle pulse.
// A drive is accepted when the port has nothing pending (or in the RELEASE
// cycle of its own grant). o_driveNext marks the single ISSUE cycle.
// i_freeNext is honoured only in ISSUE/WAIT. o_freeN marks the RELEASE cycle.
// o_sel/o_addr are valid from ISSUE through RELEASE.
//
// Optional feature: define MEM_SCHED_TIMEOUT_EN to force a release after
// TIMEOUT_CYC WAIT cycles without completion (o_timeout pulses with o_freeN).
//
// Ports:
//   clk, rst (async, active-low)
//   i_drive0/i_addr0, o_free0  : requester 0
//   i_drive1/i_addr1, o_free1  : requester 1
//   o_driveNext/o_addr/o_sel   : memory access start, address, granted port
//   i_freeNext                 : memory completion
//   o_overrun                  : sticky, drive arrived while already pending
//   o_timeout                  : forced-release pulse
//   o_dbg_state                : FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RELEASE)
module mem_port_scheduler #(
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_drive0,
  input  logic [ADDR_W-1:0] i_addr0,
  output logic              o_free0,
  input  logic              i_drive1,
  input  logic [ADDR_W-1:0] i_addr1,
  output logic              o_free1,
  output logic              o_driveNext,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_sel,
  input  logic              i_freeNext,
  output logic              o_overrun,
  output logic              o_timeout,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_pend0;
  logic                r_pend1;
  logic [ADDR_W-1:0]   r_addr0;
  logic [ADDR_W-1:0]   r_addr1;
  logic                r_last;

  logic                r_drive_next;
  logic                r_free0;
  logic                r_free1;
  logic                r_sel;
  logic [ADDR_W-1:0]   r_addr_out;
  logic                r_overrun;
  logic                r_timeout;

  logic                w_pick;
  logic                w_to_fire;
  logic                w_rel_clr0;
  logic                w_rel_clr1;
  logic                w_set0;
  logic                w_set1;
  logic                w_ovr0;
  logic                w_ovr1;

  // The granted port's pend clears in RELEASE; a drive from that same port in
  // that cycle is a fresh request, so it is accepted and wins over the clear.
  assign w_rel_clr0 = (r_state == S_RELEASE) && !r_sel;
  assign w_rel_clr1 = (r_state == S_RELEASE) &&  r_sel;
  assign w_set0     = i_drive0 && (!r_pend0 || w_rel_clr0);
  assign w_set1     = i_drive1 && (!r_pend1 || w_rel_clr1);
  assign w_ovr0     = i_drive0 && r_pend0 && !w_rel_clr0;
  assign w_ovr1     = i_drive1 && r_pend1 && !w_rel_clr1;

  // Both pending: the port that was not granted last. Otherwise the only one.
  assign w_pick = (r_pend0 && r_pend1) ? ~r_last : r_pend1;

`ifdef MEM_SCHED_TIMEOUT_EN
  logic [15:0] r_to_cnt;

  // Counter value k means k+1 WAIT cycles have elapsed at the coming edge.
  assign w_to_fire = (r_state == S_WAIT) && !i_freeNext &&
                     (r_to_cnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_to_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end
  end
`else
  assign w_to_fire = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (r_pend0 || r_pend1) w_state_nxt = S_ISSUE;
      S_ISSUE:   w_state_nxt = i_freeNext ? S_RELEASE : S_WAIT;
      S_WAIT:    if (i_freeNext || w_to_fire) w_state_nxt = S_RELEASE;
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_pend0      <= 1'b0;
      r_pend1      <= 1'b0;
      r_addr0      <= '0;
      r_addr1      <= '0;
      r_last       <= 1'b1;
      r_drive_next <= 1'b0;
      r_free0      <= 1'b0;
      r_free1      <= 1'b0;
      r_sel        <= 1'b0;
      r_addr_out   <= '0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_set0)          r_pend0 <= 1'b1;
      else if (w_rel_clr0) r_pend0 <= 1'b0;
      if (w_set1)          r_pend1 <= 1'b1;
      else if (w_rel_clr1) r_pend1 <= 1'b0;

      if (w_set0) r_addr0 <= i_addr0;
      if (w_set1) r_addr1 <= i_addr1;

      if (w_ovr0 || w_ovr1) r_overrun <= 1'b1;

      // Grant is latched only on IDLE->ISSUE, so o_sel/o_addr stay stable
      // for the whole access.
      if (r_state == S_IDLE && (r_pend0 || r_pend1)) begin
        r_sel      <= w_pick;
        r_addr_out <= w_pick ? r_addr1 : r_addr0;
      end

      if (r_state == S_RELEASE) r_last <= r_sel;

      // Pulses are registered from the next state so each is high exactly
      // for the cycle spent in the matching state.
      r_drive_next <= (w_state_nxt == S_ISSUE);
      r_free0      <= (w_state_nxt == S_RELEASE) && !r_sel;
      r_free1      <= (w_state_nxt == S_RELEASE) &&  r_sel;
      r_timeout    <= w_to_fire;
    end
  end

  assign o_driveNext = r_drive_next;
  assign o_free0     = r_free0;
  assign o_free1     = r_free1;
  assign o_sel       = r_sel;
  assign o_addr      = r_addr_out;
  assign o_overrun   = r_overrun;
  assign o_timeout   = r_timeout;
  assign o_dbg_state = r_state;

endmodule
